// File: rtl/apb_master_ctrl.sv
// Single-outstanding APB initiator: command channel in, APB transfer out,
// response channel back with slave error and wait-state timeout reporting.
module apb_master_ctrl #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [3:0]        cmd_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    output logic [3:0]        pstrb,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    // Keep the counter at least one bit wide so TIMEOUT = 0 still elaborates.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_hit;

    assign cmd_ready   = (state == IDLE);
    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (pready || timeout_hit) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            pstrb       <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        psel   <= 1'b1;
                        pwrite <= cmd_write;
                        paddr  <= cmd_addr;
                        pwdata <= cmd_wdata;
                        pstrb  <= cmd_write ? cmd_wstrb : 4'h0;
                    end
                end
                SETUP: begin
                    penable  <= 1'b1;
                    wait_cnt <= '0;
                end
                ACCESS: begin
                    // A late pready on the limit cycle still completes normally.
                    if (pready) begin
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= (pwrite || pslverr) ? '0 : prdata;
                        rsp_err     <= pslverr;
                        rsp_timeout <= 1'b0;
                    end else if (timeout_hit) begin
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                    end else if (wait_cnt != '1) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed bench for apb_master_ctrl: the bench plays both command source and
// APB slave, stepping one clock at a time with hand-computed expectations.
module tb_apb_master_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [11:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata = '0;
    logic        pready = 1'b0;
    logic        pslverr = 1'b0;

    int checks = 0;
    int errors = 0;
    int acc_cnt;

    apb_master_ctrl #(.ADDR_W(12), .DATA_W(32), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [11:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_wstrb = strb;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        #12;
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pstrb", pstrb, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("rst_cmd_ready", cmd_ready, 1);

        // Write with one slave wait state
        issue(1'b1, 12'h00C, 32'h1234_5678, 4'hF);
        step();
        cmd_valid = 1'b0;
        chk("w_psel", psel, 1);
        chk("w_penable_setup", penable, 0);
        chk("w_cmd_ready", cmd_ready, 0);
        chk("w_paddr", paddr, 12'h00C);
        chk("w_pwdata", pwdata, 32'h1234_5678);
        chk("w_pstrb", pstrb, 4'hF);
        chk("w_pwrite", pwrite, 1);
        step();
        chk("w_penable_acc", penable, 1);
        chk("w_rsp_early", rsp_valid, 0);
        step();
        chk("w_wait_penable", penable, 1);
        chk("w_wait_rsp", rsp_valid, 0);
        chk("w_wait_pwdata", pwdata, 32'h1234_5678);
        pready = 1'b1;
        step();
        pready = 1'b0;
        chk("w_rsp_valid", rsp_valid, 1);
        chk("w_psel_off", psel, 0);
        chk("w_rsp_err", rsp_err, 0);
        chk("w_rsp_rdata", rsp_rdata, 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("w_rsp_done", rsp_valid, 0);
        chk("w_cmd_ready_back", cmd_ready, 1);

        // Zero-wait read; pready high early must be ignored in SETUP
        issue(1'b0, 12'h00C, 32'hDEAD_BEEF, 4'hF);
        prdata = 32'hFFFF_FFFF;
        pready = 1'b1;
        step();
        cmd_valid = 1'b0;
        chk("r_pstrb", pstrb, 0);
        chk("r_pwrite", pwrite, 0);
        chk("r_setup_rsp", rsp_valid, 0);
        step();
        chk("r_penable", penable, 1);
        step();
        pready = 1'b0;
        chk("r_rsp_valid", rsp_valid, 1);
        chk("r_rsp_rdata", rsp_rdata, 32'hFFFF_FFFF);
        chk("r_rsp_err", rsp_err, 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("r_rsp_done", rsp_valid, 0);

        // Slave error on a write, then 5 cycles of response backpressure
        issue(1'b1, 12'h000, 32'h0000_00AA, 4'h1);
        prdata  = 32'h5555_5555;
        pready  = 1'b1;
        pslverr = 1'b1;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        pready  = 1'b0;
        pslverr = 1'b0;
        chk("e_rsp_valid", rsp_valid, 1);
        chk("e_rsp_err", rsp_err, 1);
        chk("e_rsp_timeout", rsp_timeout, 0);
        chk("e_rsp_rdata", rsp_rdata, 0);
        issue(1'b0, 12'h004, 32'h0, 4'h0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_err", rsp_err, 1);
            chk("bp_cmd_ready", cmd_ready, 0);
            chk("bp_psel", psel, 0);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("bp_release_valid", rsp_valid, 0);
        chk("bp_release_ready", cmd_ready, 1);
        chk("bp_release_psel", psel, 0);

        // Timeout: pready never comes, held command is accepted now
        step();
        cmd_valid = 1'b0;
        chk("t_psel", psel, 1);
        step();
        acc_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (!(psel && penable)) break;
            acc_cnt++;
            step();
        end
        chk("t_access_cycles", acc_cnt, 16);
        chk("t_psel_off", psel, 0);
        chk("t_rsp_valid", rsp_valid, 1);
        chk("t_rsp_err", rsp_err, 1);
        chk("t_rsp_timeout", rsp_timeout, 1);
        chk("t_rsp_rdata", rsp_rdata, 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // pready on the 16th ACCESS cycle wins over the timeout
        issue(1'b0, 12'h008, 32'h0, 4'h0);
        prdata = 32'hA5A5_A5A5;
        step();
        cmd_valid = 1'b0;
        step();
        acc_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (!(psel && penable)) break;
            acc_cnt++;
            if (acc_cnt == 16) pready = 1'b1;
            step();
        end
        pready = 1'b0;
        chk("l_access_cycles", acc_cnt, 16);
        chk("l_rsp_valid", rsp_valid, 1);
        chk("l_rsp_timeout", rsp_timeout, 0);
        chk("l_rsp_err", rsp_err, 0);
        chk("l_rsp_rdata", rsp_rdata, 32'hA5A5_A5A5);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // Asynchronous reset during ACCESS of a read
        issue(1'b0, 12'h010, 32'h0, 4'h0);
        step();
        cmd_valid = 1'b0;
        step();
        chk("ar_in_access", penable, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_psel", psel, 0);
        chk("ar_penable", penable, 0);
        chk("ar_rsp_valid", rsp_valid, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("ar_cmd_ready", cmd_ready, 1);
        chk("ar_no_rsp", rsp_valid, 0);

        // Normal read after reset
        issue(1'b0, 12'h018, 32'h0, 4'h0);
        prdata = 32'hCAFE_0018;
        pready = 1'b1;
        step();
        cmd_valid = 1'b0;
        chk("pr_paddr", paddr, 12'h018);
        step();
        step();
        pready = 1'b0;
        chk("pr_rsp_valid", rsp_valid, 1);
        chk("pr_rsp_rdata", rsp_rdata, 32'hCAFE_0018);
        chk("pr_rsp_err", rsp_err, 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("pr_done", rsp_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_master_ctrl.md
Name: apb_master_ctrl

Overview:
- Single-outstanding APB initiator that turns simple command-channel requests into APB transfers.
- Drives register-mapped peripherals such as the timer's register block (TCR/TDR/TCMP/TIER/TISR/THCSR), which answer with pready, prdata and pslverr.
- Sits between the CPU-side or bench-side command source and the APB bus.
- Returns read data and error status on a response channel, with a wait-state timeout guard.

Parameters:
- ADDR_W, 12, APB address width.
- DATA_W, 32, APB data width (4 byte lanes).
- TIMEOUT, 16, maximum ACCESS cycles without pready before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  target address.
- cmd_wdata  in  DATA_W  write data.
- cmd_wstrb  in  4  write byte strobes.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_W  read data; 0 for writes and for errors.
- rsp_err  out  1  pslverr was seen, or timeout.
- rsp_timeout  out  1  response was a timeout abort.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- pstrb  out  4  APB strobes; 0 on reads.
- prdata  in  DATA_W  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB slave error.

Behaviour:
- Reset:
  - state = IDLE.
  - psel, penable, pwrite, paddr, pwdata, pstrb, rsp_valid, rsp_rdata, rsp_err, rsp_timeout are all 0.
  - cmd_ready = 1 once rst_n deasserts.
  - Asserting reset mid-transfer drops psel/penable immediately and discards the transfer; no response is produced.
- All outputs are registered except cmd_ready, which is (state == IDLE).
- FSM has four states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - On cmd_valid && cmd_ready, capture cmd_* into paddr/pwrite/pwdata/pstrb (pstrb = cmd_write ? cmd_wstrb : 0).
  - Assert psel and go to SETUP.
- SETUP (psel=1, penable=0): always go to ACCESS next cycle with penable=1.
- ACCESS (psel=1, penable=1):
  - If pready:
    - rsp_rdata = pwrite ? 0 : (pslverr ? 0 : prdata).
    - rsp_err = pslverr; rsp_timeout = 0.
    - Deassert psel/penable, assert rsp_valid, go to RESP.
  - Else wait_cnt increments, starting at 0 on ACCESS entry.
  - If TIMEOUT != 0 and wait_cnt == TIMEOUT-1 with pready low:
    - Abort: rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0.
    - Deassert psel/penable and go to RESP.
  - pready arriving in the same cycle as the timeout limit wins over the timeout.
- RESP: hold rsp_valid and the response fields stable until rsp_ready is sampled high, then clear rsp_valid and go to IDLE.
- paddr, pwrite, pwdata and pstrb stay stable from SETUP through the end of ACCESS. They keep their last values after the transfer; no glitching to 0 is required.
- pready and pslverr are ignored outside ACCESS.
- Latency, zero-wait slave: accept at cycle T, SETUP at T+1, ACCESS at T+2 with pready sampled, rsp_valid at T+3.
  - Minimum issue interval is 4 cycles when rsp_ready is held high.
  - Each slave wait state adds 1 cycle.
- Timer register block with a 1-cycle pready delay: pready is seen on the second ACCESS cycle, so rsp_valid comes at T+4.
- wait_cnt is $clog2(TIMEOUT+1) bits wide, saturating; it is unused when TIMEOUT = 0, in which case the block waits forever.
- cmd_ready is low in SETUP, ACCESS and RESP. There is no command buffering; the source must hold cmd_* while cmd_valid is high and not accepted.

Test Plan:
- Write 0x1234_5678 to 0x00C, wstrb 0xF, slave pready 1 cycle after penable -> psel rises at T+1, penable at T+2, paddr = 0x00C, pwdata = 0x1234_5678, pstrb = 0xF held to T+3; rsp_valid at T+4 with rsp_err = 0, rsp_rdata = 0.
- Read 0x00C, slave returns prdata 0xFFFF_FFFF with zero wait -> pstrb = 0, pwrite = 0; rsp_valid at T+3 with rsp_rdata = 0xFFFF_FFFF, rsp_err = 0.
- Write 0x000 with pslverr = 1 at pready -> rsp_err = 1, rsp_timeout = 0, rsp_rdata = 0; next command accepted after rsp_ready.
- TIMEOUT = 16, pready tied low -> ACCESS lasts exactly 16 cycles, then psel = 0 and rsp_valid = 1 with rsp_err = 1, rsp_timeout = 1; pready raised on cycle 16 instead -> normal completion.
- Backpressure: rsp_ready low for 5 cycles after rsp_valid -> response fields stable, cmd_ready = 0 throughout, no new psel; cmd_ready = 1 the cycle after the rsp_ready handshake.
- Assert rst_n low during ACCESS of a read -> psel/penable/rsp_valid go 0 asynchronously; after release, cmd_ready = 1 and a new read to 0x018 completes normally.
